// File: rtl/score_text_pkg.sv
// Shared constants, types and the 8x16 digit font for the score text overlay.
package score_text_pkg;

  localparam int FONT_W     = 8;
  localparam int FONT_H     = 16;
  localparam int NUM_DIGITS = 3;
  localparam int SCORE_W    = 10;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} conv_state_e;

  // Row 0 is the top of the glyph; bit 7 is the leftmost pixel.
  localparam logic [7:0] FONT [0:9][0:15] = '{
    '{8'h00, 8'h00, 8'h3C, 8'h66, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h3C, 8'h66, 8'h06, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h66, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h3C, 8'h66, 8'h06, 8'h06, 8'h1C, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hCC, 8'hFE, 8'h0C, 8'h0C, 8'h0C, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h7E, 8'h60, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h1C, 8'h30, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h7E, 8'h66, 8'h06, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h06, 8'h06, 8'h0C, 8'h38, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  function automatic logic [SCORE_W-1:0] sat999(input logic [SCORE_W-1:0] v);
    return (v > 10'd999) ? 10'd999 : v;
  endfunction

  function automatic bcd_t add3(input bcd_t n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/score_text_draw_bin2bcd_seq.sv
// Sequential double-dabble: saturated 10-bit binary to 3 BCD digits, one bit per cycle.
//
// state   | meaning
// IDLE    | waiting for start; latches sat999(bin)
// CONVERT | 10 add-3/shift steps, down-counter cnt_q terminates at 0
// DONE    | single cycle, publishes all 12 BCD bits at once, pulses done
module bin2bcd_seq
  import score_text_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               done,
  output logic [11:0]        bcd
);

  conv_state_e        state_q;
  logic [SCORE_W-1:0] shift_q;
  logic [11:0]        work_q;
  logic [3:0]         cnt_q;
  logic [11:0]        adj;
  logic               unused_adj_msb;

  assign adj = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
  assign unused_adj_msb = adj[11];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= sat999(bin);
            work_q  <= '0;
            cnt_q   <= 4'(SCORE_W - 1);
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          work_q  <= {adj[10:0], shift_q[SCORE_W-1]};
          shift_q <= shift_q << 1;
          if (cnt_q == 4'd0) state_q <= DONE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        DONE: begin
          bcd     <= work_q;
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_text_draw.sv
// Score text overlay: per-frame BCD conversion plus registered glyph render in a fixed box.
// Build option: SCORE_LZ_BLANK_EN enables leading-zero blanking of hundreds/tens.
module score_text_draw
  import score_text_pkg::*;
#(
  parameter logic [10:0] TEXT_X     = 11'd40,
  parameter logic [10:0] TEXT_Y     = 11'd8,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [7:0]  TEXT_COLOR = 8'hFF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               startOfFrame,
  input  logic [SCORE_W-1:0] score,
  output logic               Score_DR,
  output logic [7:0]         Score_RGBout
);

  // 12-bit box limits so a box near 2047 cannot wrap
  localparam logic [11:0] X_END = {1'b0, TEXT_X} + 12'((NUM_DIGITS * FONT_W) << SCALE_LOG2);
  localparam logic [11:0] Y_END = {1'b0, TEXT_Y} + 12'(FONT_H << SCALE_LOG2);

  logic        unused_conv_done;
  logic [11:0] disp;
  logic        in_box;
  logic [10:0] dx, dy;
  logic [1:0]  digit_idx;
  logic [2:0]  col;
  logic [3:0]  row;
  bcd_t        digit_val;
  logic        blank;
  logic [7:0]  glyph_row;
  logic        lit;
  logic        unused_bits;

  bin2bcd_seq u_b2b (
    .clk    (clk),
    .resetN (resetN),
    .start  (startOfFrame),
    .bin    (score),
    .done   (unused_conv_done),
    .bcd    (disp)
  );

  assign in_box = (pixelX >= TEXT_X) && ({1'b0, pixelX} < X_END)
               && (pixelY >= TEXT_Y) && ({1'b0, pixelY} < Y_END);

  assign dx        = pixelX - TEXT_X;
  assign dy        = pixelY - TEXT_Y;
  assign digit_idx = dx[3+SCALE_LOG2 +: 2];
  assign col       = dx[SCALE_LOG2 +: 3];
  assign row       = dy[SCALE_LOG2 +: 4];
  assign unused_bits = ^{dx, dy};

  always_comb begin
    digit_val = '0;
    case (digit_idx)
      2'd0:    digit_val = disp[11:8];
      2'd1:    digit_val = disp[7:4];
      2'd2:    digit_val = disp[3:0];
      default: digit_val = '0;
    endcase
  end

`ifdef SCORE_LZ_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (digit_idx)
      2'd0:    blank = (disp[11:8] == 4'd0);
      2'd1:    blank = (disp[11:4] == 8'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // ~col == 7-col: MSB of the font row is the leftmost pixel
  assign glyph_row = FONT[digit_val][row];
  assign lit       = in_box & glyph_row[~col] & ~blank;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      Score_DR     <= 1'b0;
      Score_RGBout <= 8'h00;
    end else begin
      Score_DR     <= lit;
      Score_RGBout <= lit ? TEXT_COLOR : 8'h00;
    end
  end

endmodule

// File: tb/tb_score_text_draw.sv
// Directed bench for score_text_draw with a pixel scoreboard and a reference glyph model.
module tb_score_text_draw;
  import score_text_pkg::*;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame;
  logic [9:0]  score;
  logic        Score_DR;
  logic [7:0]  Score_RGBout;

  int          n_pass = 0;
  int          n_total = 0;
  logic [11:0] disp_exp = 12'h000;
  logic [8:0]  exp_q [$];

  always #5 clk = ~clk;

  score_text_draw dut (
    .clk          (clk),
    .resetN       (resetN),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .startOfFrame (startOfFrame),
    .score        (score),
    .Score_DR     (Score_DR),
    .Score_RGBout (Score_RGBout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [8:0] model(input int x, input int y);
    int   dx, dy, d, c;
    bcd_t v;
    logic b;
    if (x < 40 || x >= 64 || y < 8 || y >= 24) return 9'h000;
    dx = x - 40;
    dy = y - 8;
    d  = dx / 8;
    c  = dx % 8;
    v  = (d == 0) ? disp_exp[11:8] : (d == 1) ? disp_exp[7:4] : disp_exp[3:0];
    b  = FONT[v][dy][7-c];
`ifdef SCORE_LZ_BLANK_EN
    if (d == 0 && disp_exp[11:8] == 4'd0) b = 1'b0;
    if (d == 1 && disp_exp[11:4] == 8'd0) b = 1'b0;
`endif
    return b ? {1'b1, 8'hFF} : 9'h000;
  endfunction

  task automatic pop_cmp(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check(tag, {23'd0, Score_DR, Score_RGBout}, {23'd0, e});
  endtask

  task automatic drive_pix(input int x, input int y, input string tag);
    @(negedge clk);
    pop_cmp(tag);
    pixelX = 11'(x);
    pixelY = 11'(y);
    exp_q.push_back(model(x, y));
  endtask

  task automatic flush(input string tag);
    @(negedge clk);
    pop_cmp(tag);
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1, input string tag);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        drive_pix(x, y, tag);
    flush(tag);
  endtask

  // Pulse at n0; display must still be old after 11 cycles and new after 12.
  task automatic run_conv(input logic [9:0] s, input logic [11:0] exp_new, input string tag);
    @(negedge clk);
    startOfFrame = 1'b1;
    score        = s;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (10) @(negedge clk);
    check({tag, "_pre"}, {20'd0, dut.u_b2b.bcd}, {20'd0, disp_exp});
    @(negedge clk);
    check(tag, {20'd0, dut.u_b2b.bcd}, {20'd0, exp_new});
    disp_exp = exp_new;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetN       = 1'b0;
    pixelX       = 11'd0;
    pixelY       = 11'd0;
    startOfFrame = 1'b0;
    score        = 10'd0;
    repeat (2) @(negedge clk);
    check("rst_dr",  {31'd0, Score_DR}, 32'd0);
    check("rst_rgb", {24'd0, Score_RGBout}, 32'd0);
    check("rst_bcd", {20'd0, dut.u_b2b.bcd}, 32'd0);
    resetN = 1'b1;

    scan(40, 47, 8, 23, "digit0_reset");
    scan(36, 67, 5, 26, "box_000");

    run_conv(10'd237, 12'h237, "conv_237");
    scan(36, 67, 5, 26, "box_237");

    run_conv(10'd1023, 12'h999, "conv_sat");
    scan(38, 65, 6, 25, "box_999");

    run_conv(10'd0, 12'h000, "conv_zero");
    scan(38, 65, 6, 25, "box_zero");

    // second pulse 4 cycles into CONVERT must be dropped
    @(negedge clk);
    startOfFrame = 1'b1;
    score        = 10'd237;
    @(negedge clk);
    startOfFrame = 1'b0;
    score        = 10'd500;
    repeat (3) @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (6) @(negedge clk);
    check("ignore_pre", {20'd0, dut.u_b2b.bcd}, 32'h000);
    @(negedge clk);
    check("ignore_first", {20'd0, dut.u_b2b.bcd}, 32'h237);
    disp_exp = 12'h237;
    repeat (20) @(negedge clk);
    check("ignore_hold", {20'd0, dut.u_b2b.bcd}, 32'h237);

    drive_pix(39, 8, "edge_x39");
    drive_pix(64, 8, "edge_x64");
    drive_pix(40, 7, "edge_y7");
    drive_pix(40, 24, "edge_y24");
    drive_pix(40, 8, "edge_origin");
    drive_pix(2047, 2047, "far_corner");
    drive_pix(43, 10, "lit_lag");
    flush("lit_lag");

    // reset pulse mid-CONVERT while a lit pixel of "237" is being shown
    check("pre_rst_dr", {31'd0, Score_DR}, 32'd1);
    startOfFrame = 1'b1;
    score        = 10'd500;
    @(negedge clk);
    startOfFrame = 1'b0;
    repeat (4) @(negedge clk);
    resetN = 1'b0;
    #1;
    check("midrst_dr",  {31'd0, Score_DR}, 32'd0);
    check("midrst_rgb", {24'd0, Score_RGBout}, 32'd0);
    check("midrst_bcd", {20'd0, dut.u_b2b.bcd}, 32'd0);
    @(negedge clk);
    resetN   = 1'b1;
    disp_exp = 12'h000;
    repeat (20) @(negedge clk);
    check("abort_bcd", {20'd0, dut.u_b2b.bcd}, 32'd0);
    scan(38, 65, 6, 25, "box_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
